inst_fifo: RTL and testbench

//  Dual-port instruction buffer between fetch (IF) and decode (ID). It accepts 0-2

---
 rtl/inst_fifo.sv | 153 +++++++++++++++
 tb/tb_inst_fifo.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/inst_fifo.sv
// Dual-port instruction buffer between fetch and decode: accepts 0-2 {pc,inst}
// pairs per cycle and presents the oldest two entries to the dual-issue decoder.
module inst_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      fifo_rst,
    input  logic                      write_en1,
    input  logic                      write_en2,
    input  logic [31:0]               write_addr1,
    input  logic [31:0]               write_inst1,
    input  logic [31:0]               write_addr2,
    input  logic [31:0]               write_inst2,
    input  logic                      read_en1,
    input  logic                      read_en2,
    output logic [31:0]               read_addr1,
    output logic [31:0]               read_inst1,
    output logic [31:0]               read_addr2,
    output logic [31:0]               read_inst2,
    output logic                      empty,
    output logic                      almost_empty,
    output logic                      full,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int XW = PW + 2;

    localparam logic [XW-1:0] DEPTH_X = XW'(DEPTH);
    localparam logic [CW-1:0] FULL_TH = CW'(DEPTH - 1);

    // Storage is deliberately not reset; validity is tracked by count alone.
    logic [31:0] mem_addr_q [DEPTH];
    logic [31:0] mem_inst_q [DEPTH];

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    logic [1:0]    req_pop;
    logic [1:0]    npop;
    logic [1:0]    npush;
    logic [1:0]    nstore;
    logic [XW-1:0] free_slots;
    logic          wr1_en;
    logic          wr2_en;
    logic [PW-1:0] wptr_p1;
    logic [PW-1:0] rptr_p1;

    assign wptr_p1 = wptr_q + PW'(1);
    assign rptr_p1 = rptr_q + PW'(1);

    // Pop request clamped to what is actually held.
    always_comb begin
        req_pop = 2'd0;
        if (read_en1) begin
            req_pop = read_en2 ? 2'd2 : 2'd1;
        end
        npop = req_pop;
        if (count_q == CW'(0)) begin
            npop = 2'd0;
        end else if (count_q == CW'(1) && req_pop == 2'd2) begin
            npop = 2'd1;
        end
    end

    // Slots released by this edge's pops are available to this edge's pushes.
    always_comb begin
        npush = 2'd0;
        if (write_en1) begin
            npush = write_en2 ? 2'd2 : 2'd1;
        end
        free_slots = DEPTH_X - XW'(count_q) + XW'(npop);
        if (free_slots >= XW'(npush)) begin
            nstore = npush;
        end else begin
            nstore = free_slots[1:0];
        end
        wr1_en = !fifo_rst && (nstore != 2'd0);
        wr2_en = !fifo_rst && (nstore == 2'd2);
    end

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (fifo_rst) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            wptr_d  = wptr_q + PW'(nstore);
            rptr_d  = rptr_q + PW'(npop);
            count_d = count_q + CW'(nstore) - CW'(npop);
            if (nstore != npush) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr1_en) begin
            mem_addr_q[wptr_q] <= write_addr1;
            mem_inst_q[wptr_q] <= write_inst1;
        end
        if (wr2_en) begin
            mem_addr_q[wptr_p1] <= write_addr2;
            mem_inst_q[wptr_p1] <= write_inst2;
        end
    end

    // Read slots and flags depend only on registered state, never on enables.
    always_comb begin
        read_addr1 = 32'd0;
        read_inst1 = 32'd0;
        read_addr2 = 32'd0;
        read_inst2 = 32'd0;
        if (count_q != CW'(0)) begin
            read_addr1 = mem_addr_q[rptr_q];
            read_inst1 = mem_inst_q[rptr_q];
        end
        if (count_q >= CW'(2)) begin
            read_addr2 = mem_addr_q[rptr_p1];
            read_inst2 = mem_inst_q[rptr_p1];
        end
    end

    assign empty        = (count_q == CW'(0));
    assign almost_empty = (count_q == CW'(1));
    assign full         = (count_q >= FULL_TH);
    assign count        = count_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_inst_fifo.sv
// Bench for inst_fifo: a queue model of the buffer predicts each popped entry
// and the registered flags; directed scenarios followed by random traffic.
module tb_inst_fifo;

  localparam int DEPTH = 16;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_rst;
  logic          write_en1, write_en2;
  logic [31:0]   write_addr1, write_inst1, write_addr2, write_inst2;
  logic          read_en1, read_en2;
  logic [31:0]   read_addr1, read_inst1, read_addr2, read_inst2;
  logic          empty, almost_empty, full, overflow;
  logic [CW-1:0] count;

  inst_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .fifo_rst(fifo_rst),
    .write_en1(write_en1), .write_en2(write_en2),
    .write_addr1(write_addr1), .write_inst1(write_inst1),
    .write_addr2(write_addr2), .write_inst2(write_inst2),
    .read_en1(read_en1), .read_en2(read_en2),
    .read_addr1(read_addr1), .read_inst1(read_inst1),
    .read_addr2(read_addr2), .read_inst2(read_inst2),
    .empty(empty), .almost_empty(almost_empty), .full(full),
    .count(count), .overflow(overflow)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard: each entry is {pc, inst}
  logic [63:0] exp_q[$];
  logic        ov_m;
  int          n_vec;
  int          n_bad;
  logic [31:0] next_pc;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'h5a5a_0000;
  endfunction

  task automatic check_state();
    logic [63:0] h1, h2;
    int sz;
    sz = exp_q.size();
    h1 = (sz >= 1) ? exp_q[0] : 64'd0;
    h2 = (sz >= 2) ? exp_q[1] : 64'd0;
    check_val("count", 64'(count), 64'(sz));
    check_val("empty", 64'(empty), 64'(sz == 0));
    check_val("almost_empty", 64'(almost_empty), 64'(sz == 1));
    check_val("full", 64'(full), 64'(sz > DEPTH - 2));
    check_val("overflow", 64'(overflow), 64'(ov_m));
    check_val("slot1", {read_addr1, read_inst1}, h1);
    check_val("slot2", {read_addr2, read_inst2}, h2);
  endtask

  // driver: called just after a negedge; applies one edge of traffic
  task automatic cycle(input bit w1, input bit w2, input bit r1, input bit r2, input bit f);
    logic [63:0] e1, e2, got;
    int npop, npush, free;
    check_state();
    e1 = {next_pc, inst_of(next_pc)};
    e2 = {next_pc + 32'd4, inst_of(next_pc + 32'd4)};
    write_en1 = w1; write_en2 = w2;
    {write_addr1, write_inst1} = e1;
    {write_addr2, write_inst2} = e2;
    read_en1 = r1; read_en2 = r2; fifo_rst = f;
    if (f) begin
      exp_q.delete();
    end else begin
      npop = r1 ? (r2 ? 2 : 1) : 0;
      if (npop > exp_q.size()) npop = exp_q.size();
      for (int k = 0; k < npop; k++) begin
        got = (k == 0) ? {read_addr1, read_inst1} : {read_addr2, read_inst2};
        check_val("pop", got, exp_q.pop_front());
      end
      npush = w1 ? (w2 ? 2 : 1) : 0;
      free = DEPTH - exp_q.size();
      if (npush >= 1 && free >= 1) begin exp_q.push_back(e1); next_pc += 32'd4; end
      if (npush == 2 && free >= 2) begin exp_q.push_back(e2); next_pc += 32'd4; end
      if (npush > free) ov_m = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    write_en1 = 1'b0; write_en2 = 1'b0;
    read_en1 = 1'b0; read_en2 = 1'b0; fifo_rst = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_bad = 0; ov_m = 1'b0;
    rst = 1'b1; fifo_rst = 1'b0;
    write_en1 = 1'b0; write_en2 = 1'b0; read_en1 = 1'b0; read_en2 = 1'b0;
    write_addr1 = '0; write_inst1 = '0; write_addr2 = '0; write_inst2 = '0;
    next_pc = 32'hbfc0_0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_state();
    rst = 1'b0;
    @(negedge clk);

    // 1-2) reset state, then a single pair in and out
    cycle(1, 1, 0, 0, 0);
    check_val("pair_head", 64'(read_addr1), 64'h0000_0000_bfc0_0000);
    check_val("pair_next", 64'(read_addr2), 64'h0000_0000_bfc0_0004);
    cycle(0, 0, 1, 1, 0);
    check_val("pair_drained", 64'(empty), 64'd1);

    // 3) fill to full, then overflow with one slot freed
    for (int i = 0; i < 7; i++) cycle(1, 1, 0, 0, 0);
    check_val("fill14_count", 64'(count), 64'd14);
    check_val("fill14_full", 64'(full), 64'd0);
    cycle(1, 1, 0, 0, 0);
    check_val("fill16_full", 64'(full), 64'd1);
    cycle(1, 1, 1, 0, 0);
    check_val("ovf_count", 64'(count), 64'd16);
    check_val("ovf_flag", 64'(overflow), 64'd1);
    cycle(0, 0, 1, 1, 0);
    while (exp_q.size() > 0) cycle(0, 0, 1, 1, 0);

    // 4) steady push-2/pop-2 across pointer wrap at count 3
    cycle(1, 1, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) cycle(1, 1, 1, 1, 0);
    check_val("wrap_count", 64'(count), 64'd3);

    // 5) count 1, pop two requested while a pair arrives
    cycle(0, 0, 1, 1, 0);
    check_val("ae_before", 64'(almost_empty), 64'd1);
    cycle(1, 1, 1, 1, 0);
    check_val("ae_after_count", 64'(count), 64'd2);

    // 6) flush with traffic, then asynchronous reset between edges
    while (exp_q.size() < 9) cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 1, 0, 1);
    check_val("flush_empty", 64'(empty), 64'd1);
    check_val("flush_ovf_kept", 64'(overflow), 64'd1);
    cycle(1, 1, 0, 0, 1);
    for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0, 0);
    #2 rst = 1'b1;
    #1 check_val("async_count", 64'(count), 64'd0);
    check_val("async_ovf", 64'(overflow), 64'd0);
    exp_q.delete(); ov_m = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // random traffic with occasional flushes
    for (int i = 0; i < 300; i++) begin
      cycle($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 1), $urandom_range(0, 31) == 0);
    end
    check_state();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
